beam_sweep_controller: RTL and testbench

Upstream sequencer for transmit_beamformer. Steps the beam angle index across a configured range. For each angle it runs a dwell: a settle window, then a transmit burst window, then an echo listen window. It drives beam_angle into the beamformer, gates the transmit burst, and marks listen windows and per-angle completion for the receive/ranging path.

---
 rtl/sonic_sight_pkg.sv | 26 ++
 rtl/beam_sweep_controller_dwell_timer.sv | 36 +++
 rtl/beam_sweep_controller.sv | 183 ++++++++++++++++++
 tb/tb_beam_sweep_controller.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_sight_pkg.sv
// Shared types and constants for the sonic_sight beam sweep and transmit path.
package sonic_sight_pkg;

    localparam int unsigned CLK_FREQ            = 100_000_000;
    localparam int unsigned TARGET_FREQ         = 40_000;
    localparam int unsigned ANGLE_WIDTH         = 7;
    localparam int unsigned DEF_SETTLE_CYCLES   = 2_500;
    localparam int unsigned DEF_BURST_CYCLES    = 25_000;
    localparam int unsigned DEF_LISTEN_CYCLES   = 3_000_000;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        BURST,
        LISTEN,
        ADVANCE
    } sweep_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/beam_sweep_controller_dwell_timer.sv
// Loadable down-counter; done_out flags the final cycle of the loaded window.
module dwell_timer
    import sonic_sight_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    output logic             done_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_val_in;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_out = (count_q == '0);

endmodule

// File: rtl/beam_sweep_controller.sv
// Steps the beam angle across a range, running settle / burst / listen dwells per angle.
module beam_sweep_controller
    import sonic_sight_pkg::*;
#(
    parameter int unsigned ANGLE_WIDTH   = sonic_sight_pkg::ANGLE_WIDTH,
    parameter int unsigned ANGLE_MIN     = 0,
    parameter int unsigned ANGLE_MAX     = 127,
    parameter int unsigned ANGLE_STEP    = 1,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int unsigned LISTEN_CYCLES = DEF_LISTEN_CYCLES,
    parameter int unsigned PINGPONG      = 0
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   continuous_in,
    input  logic                   abort_in,
    output logic [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                   burst_en_out,
    output logic                   listen_out,
    output logic                   dwell_done_out,
    output logic [ANGLE_WIDTH-1:0] dwell_angle_out,
    output logic                   sweep_done_out,
    output logic                   busy_out
);

    localparam int unsigned MAX_DUR = max3(SETTLE_CYCLES, BURST_CYCLES, LISTEN_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_DUR) + 1;
    localparam int unsigned AWX     = ANGLE_WIDTH + 1;

    localparam logic [ANGLE_WIDTH-1:0] MIN_A  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic [ANGLE_WIDTH-1:0] MAX_A  = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic [ANGLE_WIDTH:0]   MIN_X  = AWX'(ANGLE_MIN);
    localparam logic [ANGLE_WIDTH:0]   MAX_X  = AWX'(ANGLE_MAX);
    localparam logic [ANGLE_WIDTH:0]   STEP_X = AWX'(ANGLE_STEP);

    sweep_state_t             state_q, state_d;
    logic [ANGLE_WIDTH-1:0]   angle_q, angle_d;
    logic [ANGLE_WIDTH-1:0]   dwell_angle_q, dwell_angle_d;
    logic                     dir_up_q, dir_up_d;
    logic                     burst_q, burst_d;
    logic                     listen_q, listen_d;
    logic                     dwell_done_q, dwell_done_d;
    logic                     sweep_done_q, sweep_done_d;
    logic                     busy_q, busy_d;

    logic                     timer_load;
    logic [CNT_W-1:0]         timer_load_val;
    logic                     timer_done;
    logic                     at_end;

    // Extra headroom bit keeps the up step from wrapping before the clamp.
    function automatic logic [ANGLE_WIDTH-1:0] step_angle(input logic [ANGLE_WIDTH-1:0] cur,
                                                          input logic up);
        logic [ANGLE_WIDTH:0] cur_x;
        logic [ANGLE_WIDTH:0] nxt;
        cur_x = {1'b0, cur};
        if (up) begin
            nxt = cur_x + STEP_X;
            if (nxt > MAX_X) begin
                nxt = MAX_X;
            end
        end else if ((cur_x - MIN_X) < STEP_X) begin
            nxt = MIN_X;
        end else begin
            nxt = cur_x - STEP_X;
        end
        return nxt[ANGLE_WIDTH-1:0];
    endfunction

    assign at_end = dir_up_q ? (angle_q == MAX_A) : (angle_q == MIN_A);

    always_comb begin
        state_d       = state_q;
        angle_d       = angle_q;
        dir_up_d      = dir_up_q;
        dwell_angle_d = dwell_angle_q;
        dwell_done_d  = 1'b0;
        sweep_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d  = SETTLE;
                    angle_d  = MIN_A;
                    dir_up_d = 1'b1;
                end
            end
            SETTLE: if (timer_done) state_d = BURST;
            BURST:  if (timer_done) state_d = LISTEN;
            LISTEN: begin
                // Sweep-end decision is taken here so the pulses line up with ADVANCE.
                if (timer_done) begin
                    state_d       = ADVANCE;
                    dwell_done_d  = 1'b1;
                    dwell_angle_d = angle_q;
                    sweep_done_d  = at_end && !continuous_in;
                end
            end
            ADVANCE: begin
                state_d = SETTLE;
                if (!at_end) begin
                    angle_d = step_angle(angle_q, dir_up_q);
                end else if (sweep_done_q) begin
                    state_d  = IDLE;
                    angle_d  = MIN_A;
                    dir_up_d = 1'b1;
                end else if (PINGPONG != 0) begin
                    dir_up_d = !dir_up_q;
                    angle_d  = step_angle(angle_q, !dir_up_q);
                end else begin
                    angle_d  = MIN_A;
                    dir_up_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_in) begin
            state_d      = IDLE;
            angle_d      = MIN_A;
            dir_up_d     = 1'b1;
            dwell_done_d = 1'b0;
            sweep_done_d = 1'b0;
        end

        busy_d   = (state_d != IDLE);
        burst_d  = (state_d == BURST);
        listen_d = (state_d == LISTEN);

        timer_load = (state_d != state_q);
        case (state_d)
            SETTLE:  timer_load_val = CNT_W'(SETTLE_CYCLES - 1);
            BURST:   timer_load_val = CNT_W'(BURST_CYCLES - 1);
            LISTEN:  timer_load_val = CNT_W'(LISTEN_CYCLES - 1);
            default: timer_load_val = '0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            angle_q       <= MIN_A;
            dir_up_q      <= 1'b1;
            dwell_angle_q <= '0;
            burst_q       <= 1'b0;
            listen_q      <= 1'b0;
            dwell_done_q  <= 1'b0;
            sweep_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            angle_q       <= angle_d;
            dir_up_q      <= dir_up_d;
            dwell_angle_q <= dwell_angle_d;
            burst_q       <= burst_d;
            listen_q      <= listen_d;
            dwell_done_q  <= dwell_done_d;
            sweep_done_q  <= sweep_done_d;
            busy_q        <= busy_d;
        end
    end

    dwell_timer #(
        .WIDTH(CNT_W)
    ) u_dwell_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_in    (timer_load),
        .load_val_in(timer_load_val),
        .done_out   (timer_done)
    );

    assign beam_angle_out  = angle_q;
    assign burst_en_out    = burst_q;
    assign listen_out      = listen_q;
    assign dwell_done_out  = dwell_done_q;
    assign dwell_angle_out = dwell_angle_q;
    assign sweep_done_out  = sweep_done_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_beam_sweep_controller.sv
// Directed bench: three controller instances (step 1, ping-pong, step 2) on shared inputs.
module tb_beam_sweep_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic abort = 1'b0;

    logic [6:0] angle       [3];
    logic [6:0] dwell_angle [3];
    logic       burst       [3];
    logic       listen      [3];
    logic       dwell_done  [3];
    logic       sweep_done  [3];
    logic       busy        [3];

    int checks = 0;
    int fails  = 0;

    int got [16];
    int n_got;
    int sd_cnt;
    int sd_cycle;
    int max_angle;

    always #5 clk = ~clk;

    beam_sweep_controller #(
        .ANGLE_WIDTH(7), .ANGLE_MIN(10), .ANGLE_MAX(13), .ANGLE_STEP(1),
        .SETTLE_CYCLES(2), .BURST_CYCLES(3), .LISTEN_CYCLES(4), .PINGPONG(0)
    ) dut0 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont), .abort_in(abort),
        .beam_angle_out(angle[0]), .burst_en_out(burst[0]), .listen_out(listen[0]),
        .dwell_done_out(dwell_done[0]), .dwell_angle_out(dwell_angle[0]),
        .sweep_done_out(sweep_done[0]), .busy_out(busy[0])
    );

    beam_sweep_controller #(
        .ANGLE_WIDTH(7), .ANGLE_MIN(10), .ANGLE_MAX(13), .ANGLE_STEP(1),
        .SETTLE_CYCLES(2), .BURST_CYCLES(3), .LISTEN_CYCLES(4), .PINGPONG(1)
    ) dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont), .abort_in(abort),
        .beam_angle_out(angle[1]), .burst_en_out(burst[1]), .listen_out(listen[1]),
        .dwell_done_out(dwell_done[1]), .dwell_angle_out(dwell_angle[1]),
        .sweep_done_out(sweep_done[1]), .busy_out(busy[1])
    );

    beam_sweep_controller #(
        .ANGLE_WIDTH(7), .ANGLE_MIN(10), .ANGLE_MAX(13), .ANGLE_STEP(2),
        .SETTLE_CYCLES(2), .BURST_CYCLES(3), .LISTEN_CYCLES(4), .PINGPONG(0)
    ) dut2 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont), .abort_in(abort),
        .beam_angle_out(angle[2]), .burst_en_out(burst[2]), .listen_out(listen[2]),
        .dwell_done_out(dwell_done[2]), .dwell_angle_out(dwell_angle[2]),
        .sweep_done_out(sweep_done[2]), .busy_out(busy[2])
    );

    // {busy, burst_en, listen, dwell_done, sweep_done}
    function automatic logic [4:0] flags(input int i);
        return {busy[i], burst[i], listen[i], dwell_done[i], sweep_done[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic abort_all();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    // Records dwell angles, sweep_done pulses and the peak angle seen on one instance.
    task automatic run_collect(input int idx, input int ncyc);
        n_got = 0;
        sd_cnt = 0;
        sd_cycle = -1;
        max_angle = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (dwell_done[idx] === 1'b1 && n_got < 16) begin
                got[n_got] = int'(dwell_angle[idx]);
                n_got++;
            end
            if (sweep_done[idx] === 1'b1) begin
                sd_cnt++;
                sd_cycle = c;
            end
            if (int'(angle[idx]) > max_angle) max_angle = int'(angle[idx]);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (flags(i) !== 5'b00000) begin
                fails++;
                $display("FAIL reset_flags dut%0d: got %b want 00000", i, flags(i));
            end
            checks++;
            if (angle[i] !== 7'd10 || dwell_angle[i] !== 7'd0) begin
                fails++;
                $display("FAIL reset_angles dut%0d: got %0d/%0d want 10/0", i, angle[i], dwell_angle[i]);
            end
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_sweep();
        logic [4:0] ef;
        int p;
        int ea;
        cont = 1'b0;
        pulse_start();
        for (int c = 1; c <= 41; c++) begin
            p  = (c - 1) % 10;
            ea = (c <= 40) ? 10 + (c - 1) / 10 : 10;
            if (c == 41) ef = 5'b00000;
            else ef = {1'b1, (p >= 2 && p <= 4), (p >= 5 && p <= 8), (p == 9), (c == 40)};
            checks++;
            if (flags(0) !== ef) begin
                fails++;
                $display("FAIL single_flags cycle %0d: got %b want %b", c, flags(0), ef);
            end
            checks++;
            if (angle[0] !== 7'(ea)) begin
                fails++;
                $display("FAIL single_angle cycle %0d: got %0d want %0d", c, angle[0], ea);
            end
            if (p == 9 && c <= 40) begin
                checks++;
                if (dwell_angle[0] !== 7'(ea)) begin
                    fails++;
                    $display("FAIL single_dwell_angle cycle %0d: got %0d want %0d", c, dwell_angle[0], ea);
                end
            end
            tick();
        end
        abort_all();
    endtask

    task automatic test_continuous_wrap();
        int exp_a [6] = '{10, 11, 12, 13, 10, 11};
        cont = 1'b1;
        pulse_start();
        run_collect(0, 60);
        checks++;
        if (n_got !== 6 || sd_cnt !== 0) begin
            fails++;
            $display("FAIL wrap_counts: got %0d dwells %0d sweep_done want 6 and 0", n_got, sd_cnt);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp_a[k]) begin
                fails++;
                $display("FAIL wrap_angle dwell %0d: got %0d want %0d", k, got[k], exp_a[k]);
            end
        end
        cont = 1'b0;
        abort_all();
    endtask

    task automatic test_pingpong();
        int exp_a [8] = '{10, 11, 12, 13, 12, 11, 10, 11};
        cont = 1'b1;
        pulse_start();
        run_collect(1, 80);
        checks++;
        if (n_got !== 8 || sd_cnt !== 0) begin
            fails++;
            $display("FAIL pingpong_counts: got %0d dwells %0d sweep_done want 8 and 0", n_got, sd_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== exp_a[k]) begin
                fails++;
                $display("FAIL pingpong_angle dwell %0d: got %0d want %0d", k, got[k], exp_a[k]);
            end
        end
        cont = 1'b0;
        abort_all();
    endtask

    task automatic test_step_clamp();
        int exp_a [3] = '{10, 12, 13};
        cont = 1'b0;
        pulse_start();
        run_collect(2, 31);
        checks++;
        if (n_got !== 3 || sd_cnt !== 1 || sd_cycle !== 30) begin
            fails++;
            $display("FAIL step2_counts: got %0d dwells %0d sweep_done at %0d want 3, 1 at 30",
                     n_got, sd_cnt, sd_cycle);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== exp_a[k]) begin
                fails++;
                $display("FAIL step2_angle dwell %0d: got %0d want %0d", k, got[k], exp_a[k]);
            end
        end
        checks++;
        if (max_angle !== 13) begin
            fails++;
            $display("FAIL step2_max_angle: got %0d want 13", max_angle);
        end
        checks++;
        if (busy[2] !== 1'b0 || angle[2] !== 7'd10) begin
            fails++;
            $display("FAIL step2_idle: got busy %b angle %0d want 0 and 10", busy[2], angle[2]);
        end
        abort_all();
    endtask

    task automatic test_abort();
        cont = 1'b0;
        pulse_start();
        tick();
        tick();
        tick();
        checks++;
        if (burst[0] !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre_burst: got %b want 1", burst[0]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (flags(0) !== 5'b00000 || angle[0] !== 7'd10) begin
            fails++;
            $display("FAIL abort_idle: got flags %b angle %0d want 00000 and 10", flags(0), angle[0]);
        end
        run_collect(0, 15);
        checks++;
        if (n_got !== 0 || sd_cnt !== 0) begin
            fails++;
            $display("FAIL abort_no_dwell: got %0d dwells %0d sweeps want 0 and 0", n_got, sd_cnt);
        end
        pulse_start();
        checks++;
        if (flags(0) !== 5'b10000 || angle[0] !== 7'd10) begin
            fails++;
            $display("FAIL abort_restart: got flags %b angle %0d want 10000 and 10", flags(0), angle[0]);
        end
        for (int k = 0; k < 9; k++) tick();
        checks++;
        if (dwell_done[0] !== 1'b1 || dwell_angle[0] !== 7'd10) begin
            fails++;
            $display("FAIL abort_restart_dwell: got %b/%0d want 1/10", dwell_done[0], dwell_angle[0]);
        end
        abort_all();
    endtask

    task automatic test_reset_mid_listen();
        cont = 1'b0;
        pulse_start();
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (listen[0] !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_listen: got %b want 1", listen[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (flags(0) !== 5'b00000 || angle[0] !== 7'd10) begin
            fails++;
            $display("FAIL rst_async: got flags %b angle %0d want 00000 and 10", flags(0), angle[0]);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ignored_start();
        logic [4:0] ef;
        int p;
        int ea;
        cont = 1'b0;
        pulse_start();
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 5; c <= 11; c++) begin
            p  = (c - 1) % 10;
            ea = 10 + (c - 1) / 10;
            ef = {1'b1, (p >= 2 && p <= 4), (p >= 5 && p <= 8), (p == 9), 1'b0};
            checks++;
            if (flags(0) !== ef || angle[0] !== 7'(ea)) begin
                fails++;
                $display("FAIL busy_start cycle %0d: got %b/%0d want %b/%0d", c, flags(0), angle[0], ef, ea);
            end
            tick();
        end
        abort_all();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_sweep();
        test_continuous_wrap();
        test_pingpong();
        test_step_clamp();
        test_abort();
        test_reset_mid_listen();
        test_ignored_start();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
